bbox_fetch: RTL and testbench

BBOX_FETCH -- requirements
Module: bbox_fetch

---
 rtl/bbox_pkg.sv | 27 ++
 rtl/bbox_fetch_if.sv | 33 +++
 rtl/bbox_clamp.sv | 18 +
 rtl/bbox_fetch.sv | 132 +++++++++++++
 tb/tb_bbox_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box fetch block.
package bbox_pkg;
  localparam int ADDR_W    = 8;
  localparam int SET_W     = 3;
  localparam int WIDX_W    = 2;
  localparam int RD_ADDR_W = SET_W + ADDR_W + WIDX_W;
  localparam int DATA_W    = 16;
  localparam int NUM_WORDS = 4;
  localparam int NUM_AXES  = 2;   // lane 0 = x, lane 1 = y

  localparam logic [WIDX_W-1:0] WORD_XC = 2'd0;
  localparam logic [WIDX_W-1:0] WORD_YC = 2'd1;
  localparam logic [WIDX_W-1:0] WORD_W  = 2'd2;
  localparam logic [WIDX_W-1:0] WORD_H  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_OUT} state_t;

  typedef struct packed {
    logic [SET_W-1:0]  set_idx;
    logic [ADDR_W-1:0] addr;
  } winner_t;

  // Box-memory word address: {set, anchor, word}.
  function automatic logic [RD_ADDR_W-1:0] rd_addr(winner_t w, logic [WIDX_W-1:0] word);
    return {w.set_idx, w.addr, word};
  endfunction
endpackage

// File: rtl/bbox_fetch_if.sv
// Winner stream, box-memory read port and box result port.
interface bbox_fetch_if;
  import bbox_pkg::*;

  logic                 valid_in;
  logic                 last_in;
  logic [ADDR_W-1:0]    addr_in;
  logic [SET_W-1:0]     set_in;
  logic                 mem_rd_en;
  logic [RD_ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0]    mem_rd_data;
  logic                 box_valid;
  logic                 box_ready;
  logic [DATA_W-1:0]    box_xmin;
  logic [DATA_W-1:0]    box_ymin;
  logic [DATA_W-1:0]    box_xmax;
  logic [DATA_W-1:0]    box_ymax;
  logic [SET_W-1:0]     box_set;
  logic [ADDR_W-1:0]    box_addr;
  logic                 drop_out;

  modport slave (
    input  valid_in, last_in, addr_in, set_in, mem_rd_data, box_ready,
    output mem_rd_en, mem_rd_addr, box_valid, box_xmin, box_ymin,
           box_xmax, box_ymax, box_set, box_addr, drop_out
  );

  modport master (
    output valid_in, last_in, addr_in, set_in, mem_rd_data, box_ready,
    input  mem_rd_en, mem_rd_addr, box_valid, box_xmin, box_ymin,
           box_xmax, box_ymax, box_set, box_addr, drop_out
  );
endinterface

// File: rtl/bbox_clamp.sv
// One axis of corner math: center +/- size/2, floored at 0, capped at bound.
module bbox_clamp
  import bbox_pkg::*;
(
  input  logic [DATA_W-1:0] center,
  input  logic [DATA_W-1:0] size,
  input  logic [DATA_W-1:0] bound,   // largest legal coordinate
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);
  logic [DATA_W-1:0] half;
  logic [DATA_W:0]   sum;   // extra bit so center+half cannot wrap

  assign half = size >> 1;
  assign sum  = {1'b0, center} + {1'b0, half};
  assign lo   = (center < half) ? '0 : center - half;
  assign hi   = (sum > {1'b0, bound}) ? bound : sum[DATA_W-1:0];
endmodule

// File: rtl/bbox_fetch.sv
// Fetches the four box words of a frame winner and emits clamped corners.
module bbox_fetch
  import bbox_pkg::*;
#(
  parameter int IMG_W   = 416,
  parameter int IMG_H   = 416,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  bbox_fetch_if.slave bus
);
  state_t  state, state_nxt;
  winner_t cur, pend, trig_w;
  logic    pend_vld, drop_q;
  logic    trig, rd_en, load, calc, cap;

  logic [WIDX_W-1:0]                   req_cnt, cap_cnt;
  logic [MEM_LAT-1:0]                  vld_pipe;   // read-enable delayed to the data return
  logic [NUM_WORDS-1:0][DATA_W-1:0]    words;
  logic [NUM_AXES-1:0][DATA_W-1:0]     center, size, bound, lo_c, hi_c, lo_q, hi_q;
  winner_t                             box_id;

  assign trig   = bus.valid_in & bus.last_in;
  assign trig_w = '{set_idx: bus.set_in, addr: bus.addr_in};
  assign cap    = vld_pipe[MEM_LAT-1];

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;

  // Next-state: four requests, wait for the fourth word, one compute cycle, hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (trig || pend_vld)                state_nxt = S_REQ;
      S_REQ:  if (req_cnt == WORD_H)               state_nxt = S_WAIT;
      S_WAIT: if (cap && cap_cnt == WORD_H)        state_nxt = S_CALC;
      S_CALC:                                      state_nxt = S_OUT;
      S_OUT:  if (bus.box_ready)                   state_nxt = S_IDLE;
      default:                                     state_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes.
  always_comb begin
    rd_en = (state == S_REQ);
    load  = (state == S_IDLE) && (trig || pend_vld);
    calc  = (state == S_CALC);
  end

  // One-deep pending slot; a fresh trigger displaces an older one and reports it.
  // A trigger landing in IDLE wins over the pending entry, which then stays queued.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (trig && state != S_IDLE) begin
        pend     <= trig_w;
        pend_vld <= 1'b1;
        drop_q   <= pend_vld;
      end else if (load && !trig) begin
        pend_vld <= 1'b0;
      end
    end

  // Current winner and request word counter.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur     <= '0;
      req_cnt <= '0;
    end else begin
      if (load)  cur     <= trig ? trig_w : pend;
      if (rd_en) req_cnt <= req_cnt + 1'b1;
    end

  // Return path: data is taken exactly MEM_LAT cycles after each strobe, in issue order.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld_pipe <= '0;
      cap_cnt  <= '0;
      words    <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (cap) begin
        words[cap_cnt] <= bus.mem_rd_data;
        cap_cnt        <= cap_cnt + 1'b1;
      end
    end

  assign center = {words[WORD_YC], words[WORD_XC]};
  assign size   = {words[WORD_H],  words[WORD_W]};
  assign bound  = {16'(IMG_H - 1), 16'(IMG_W - 1)};

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    bbox_clamp u_clamp (
      .center (center[a]),
      .size   (size[a]),
      .bound  (bound[a]),
      .lo     (lo_c[a]),
      .hi     (hi_c[a])
    );
  end

  // Result registers, loaded in CALC and held through OUT.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      box_id <= '0;
    end else if (calc) begin
      lo_q   <= lo_c;
      hi_q   <= hi_c;
      box_id <= cur;
    end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? rd_addr(cur, req_cnt) : '0;
  assign bus.box_valid   = (state == S_OUT);
  assign bus.box_xmin    = lo_q[0];
  assign bus.box_ymin    = lo_q[1];
  assign bus.box_xmax    = hi_q[0];
  assign bus.box_ymax    = hi_q[1];
  assign bus.box_set     = box_id.set_idx;
  assign bus.box_addr    = box_id.addr;
  assign bus.drop_out    = drop_q;
endmodule

// File: tb/tb_bbox_fetch.sv
// Directed bench for bbox_fetch with a transaction-level reference model.
module tb_bbox_fetch;
  localparam int MEM_LAT = 2;
  localparam int IMG_W   = 416;
  localparam int IMG_H   = 416;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0, n_err = 0;
  int   n_boxes = 0, n_drops = 0, n_rd = 0;

  logic [15:0] mem [0:8191];
  logic [15:0] sched [int];

  bbox_fetch_if bus();

  bbox_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int mem_idx(int s, int a, int k);
    return s * 1024 + a * 4 + k;
  endfunction

  function automatic int lo_of(int c, int sz);
    return (c < sz / 2) ? 0 : c - sz / 2;
  endfunction

  function automatic int hi_of(int c, int sz, int img);
    return (c + sz / 2 > img - 1) ? img - 1 : c + sz / 2;
  endfunction

  task automatic put_box(input int s, input int a, input int xc, input int yc, input int w, input int h);
    mem[mem_idx(s, a, 0)] = 16'(xc);
    mem[mem_idx(s, a, 1)] = 16'(yc);
    mem[mem_idx(s, a, 2)] = 16'(w);
    mem[mem_idx(s, a, 3)] = 16'(h);
  endtask

  // Box memory: answers each strobe MEM_LAT cycles later, noise otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en) sched[cyc + MEM_LAT] = mem[int'(bus.mem_rd_addr)];
      if (sched.exists(cyc)) begin
        bus.mem_rd_data = sched[cyc];
        sched.delete(cyc);
      end else begin
        bus.mem_rd_data = 16'($urandom);
      end
    end
  end

  // Reference model: a winner is accepted when idle (trigger first, else pending);
  // it reads on the 4 cycles after acceptance and presents its box from acceptance+MEM_LAT+5
  // until taken. Triggers while busy go to a one-deep slot.
  initial begin
    bit busy = 0, pend_vld = 0, drop_nxt = 0, exp_rd, exp_v;
    int s_edge = 0, cur_s = 0, cur_a = 0, pend_s = 0, pend_a = 0;
    int xc, yc, w, h;
    logic [12:0] exp_addr;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_rd_addr", bus.mem_rd_addr, 0);
        chk("rst_valid", bus.box_valid, 0);
        chk("rst_drop", bus.drop_out, 0);
        chk("rst_corners", {bus.box_xmin | bus.box_ymin | bus.box_xmax | bus.box_ymax}, 0);
        chk("rst_id", {bus.box_set, bus.box_addr}, 0);
        busy = 0; pend_vld = 0; drop_nxt = 0;
      end else begin
        exp_rd   = busy && cyc >= s_edge && cyc <= s_edge + 3;
        exp_addr = exp_rd ? 13'(mem_idx(cur_s, cur_a, cyc - s_edge)) : 13'd0;
        exp_v    = busy && cyc >= s_edge + MEM_LAT + 5;
        chk("rd_en", bus.mem_rd_en, exp_rd);
        chk("rd_addr", bus.mem_rd_addr, exp_addr);
        chk("box_valid", bus.box_valid, exp_v);
        chk("drop_out", bus.drop_out, drop_nxt);
        if (exp_v) begin
          xc = mem[mem_idx(cur_s, cur_a, 0)];
          yc = mem[mem_idx(cur_s, cur_a, 1)];
          w  = mem[mem_idx(cur_s, cur_a, 2)];
          h  = mem[mem_idx(cur_s, cur_a, 3)];
          chk("xmin", bus.box_xmin, lo_of(xc, w));
          chk("ymin", bus.box_ymin, lo_of(yc, h));
          chk("xmax", bus.box_xmax, hi_of(xc, w, IMG_W));
          chk("ymax", bus.box_ymax, hi_of(yc, h, IMG_H));
          chk("box_id", {bus.box_set, bus.box_addr}, {3'(cur_s), 8'(cur_a)});
        end
        if (bus.box_valid && bus.box_ready) n_boxes++;
        if (bus.drop_out) n_drops++;
        if (bus.mem_rd_en) n_rd++;
        // advance across the coming edge
        drop_nxt = 0;
        if (!busy) begin
          if (bus.valid_in && bus.last_in) begin
            cur_s = bus.set_in; cur_a = bus.addr_in; s_edge = cyc + 1; busy = 1;
          end else if (pend_vld) begin
            cur_s = pend_s; cur_a = pend_a; pend_vld = 0; s_edge = cyc + 1; busy = 1;
          end
        end else begin
          if (bus.valid_in && bus.last_in) begin
            drop_nxt = pend_vld;
            pend_s = bus.set_in; pend_a = bus.addr_in; pend_vld = 1;
          end
          if (exp_v && bus.box_ready) busy = 0;
        end
      end
    end
  end

  task automatic send(input int s, input int a);
    @(posedge clk); #1;
    bus.valid_in = 1; bus.last_in = 1; bus.set_in = 3'(s); bus.addr_in = 8'(a);
    @(posedge clk); #1;
    bus.valid_in = 0; bus.last_in = 0;
    bus.set_in = 3'($urandom); bus.addr_in = 8'($urandom);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.box_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, bus.box_valid, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, d0, r0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    put_box(3, 8'h15, 200, 100, 50, 40);
    put_box(1, 8'h22, 10, 5, 40, 20);
    put_box(5, 8'hA7, 400, 410, 60, 30);
    put_box(2, 8'h40, 100, 200, 0, 0);
    put_box(0, 8'h01, 50, 60, 20, 10);
    put_box(6, 8'h7F, 123, 45, 6, 8);
    put_box(7, 8'hFF, 300, 250, 101, 51);

    bus.valid_in = 0; bus.last_in = 0; bus.set_in = 0; bus.addr_in = 0;
    bus.box_ready = 1; bus.mem_rd_data = 0;
    idle(3);
    chk("reset_valid", bus.box_valid, 0);
    chk("reset_rd_en", bus.mem_rd_en, 0);
    rst = 0;
    idle(2);

    // Basic fetch: addresses, latency and corners.
    send(3, 8'h15);
    chk("t1_rd_en", bus.mem_rd_en, 1);
    chk("t1_addr0", bus.mem_rd_addr, 13'h0C54);
    for (int k = 1; k < 4; k++) begin
      idle(1);
      chk("t1_addrk", bus.mem_rd_addr, 13'h0C54 + 13'(k));
    end
    idle(3);
    chk("t1_early_valid", bus.box_valid, 0);
    idle(1);
    chk("t1_valid_edge7", bus.box_valid, 1);
    chk("t1_xmin", bus.box_xmin, 175);
    chk("t1_ymin", bus.box_ymin, 80);
    chk("t1_xmax", bus.box_xmax, 225);
    chk("t1_ymax", bus.box_ymax, 120);
    idle(1);
    chk("t1_taken", bus.box_valid, 0);

    // Low clamp.
    send(1, 8'h22);
    wait_valid("t2_valid");
    chk("t2_xmin", bus.box_xmin, 0);
    chk("t2_ymin", bus.box_ymin, 0);
    chk("t2_xmax", bus.box_xmax, 30);
    chk("t2_ymax", bus.box_ymax, 15);
    idle(2);

    // High clamp.
    send(5, 8'hA7);
    wait_valid("t3_valid");
    chk("t3_xmin", bus.box_xmin, 370);
    chk("t3_ymin", bus.box_ymin, 395);
    chk("t3_xmax", bus.box_xmax, 415);
    chk("t3_ymax", bus.box_ymax, 415);
    idle(2);

    // Backpressure with two late triggers: the second displaces the first.
    bus.box_ready = 0;
    b0 = n_boxes; d0 = n_drops;
    send(0, 8'h01);
    wait_valid("t4_valid");
    send(6, 8'h7F);
    idle(2);
    send(7, 8'hFF);
    chk("t4_drop_pulse", bus.drop_out, 1);
    idle(5);
    chk("t4_held_xmax", bus.box_xmax, 60);
    bus.box_ready = 1;
    idle(1);
    chk("t4_released", bus.box_valid, 0);
    wait_valid("t4_second_valid");
    chk("t4_second_id", {bus.box_set, bus.box_addr}, {3'd7, 8'hFF});
    chk("t4_second_xmin", bus.box_xmin, 250);
    chk("t4_second_ymax", bus.box_ymax, 275);
    idle(20);
    chk("t4_box_count", n_boxes - b0, 2);
    chk("t4_drop_count", n_drops - d0, 1);

    // Reset two cycles into WAIT abandons the fetch.
    b0 = n_boxes;
    send(2, 8'h40);
    idle(5);
    rst = 1;
    #1;
    chk("t5_rst_valid", bus.box_valid, 0);
    chk("t5_rst_rd_en", bus.mem_rd_en, 0);
    chk("t5_rst_corner", bus.box_xmax, 0);
    idle(2);
    rst = 0;
    idle(20);
    chk("t5_no_box", n_boxes - b0, 0);

    // Zero size after reset recovery.
    send(2, 8'h40);
    wait_valid("t6_valid");
    chk("t6_x", {bus.box_xmin, bus.box_xmax}, {16'd100, 16'd100});
    chk("t6_y", {bus.box_ymin, bus.box_ymax}, {16'd200, 16'd200});
    idle(2);

    // Non-last beats never trigger.
    b0 = n_boxes; r0 = n_rd;
    bus.valid_in = 1; bus.last_in = 0;
    idle(100);
    bus.valid_in = 0;
    idle(2);
    chk("t7_no_reads", n_rd - r0, 0);
    chk("t7_no_boxes", n_boxes - b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
